// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// op-code constants, default widths and the response FIFO entry layout.
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_OPW   = 3;

    localparam logic [ALU_OPW-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OPW-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OPW-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OPW-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OPW-1:0] ALU_SLT = 3'b100;
    localparam logic [ALU_OPW-1:0] ALU_MUL = 3'b101;
    localparam logic [ALU_OPW-1:0] ALU_SHL = 3'b110;
    localparam logic [ALU_OPW-1:0] ALU_SHR = 3'b111;

    // One response: which requester issued it, the ALU result and its zero flag.
    typedef struct packed {
        logic                 id;
        logic [ALU_WIDTH-1:0] result;
        logic                 zero;
    } rsp_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Produces a one-hot grant from the request
// valids; on contention the requester that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // Grant the lone valid requester, or on contention the one not served last.
    always_comb begin
        o_grant = i_valid;
        if (i_valid == 2'b11) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters.
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; a requester holds its fields stable while valid is high and ready is
// low, and ready never depends on the requester's own operand values.
// Results are tagged with the requester id and returned through a 2-entry
// register FIFO whose head drives the rsp_* outputs.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    logic [1:0]  w_valid;
    logic [1:0]  w_grant;
    logic        w_pop;
    logic        w_can_issue;
    logic        w_issue;
    rsp_entry_t  w_new;

    logic        r_last_grant;
    logic [1:0]  r_count;
    rsp_entry_t  r_head;
    rsp_entry_t  r_tail;

    assign w_valid = {req1_valid, req0_valid};

    rr_arb2 u_rr_arb2 (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // A full FIFO can still accept when its head leaves in the same cycle.
    assign rsp_valid   = (r_count != 2'd0);
    assign w_pop       = rsp_valid & rsp_ready;
    assign w_can_issue = (r_count != 2'd2) | w_pop;

    assign req0_ready = w_grant[0] & w_can_issue & ~reset;
    assign req1_ready = w_grant[1] & w_can_issue & ~reset;
    assign w_issue    = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    // Idle cycles show requester 0's fields so the ALU inputs stay deterministic.
    assign alu_a    = w_grant[1] ? req1_a  : req0_a;
    assign alu_b    = w_grant[1] ? req1_b  : req0_b;
    assign alu_ctrl = w_grant[1] ? req1_op : req0_op;

    assign w_new = '{id: w_grant[1], result: alu_result, zero: alu_zero};

    // Priority rotates only on an actual issue, so a stalled grant keeps its turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (w_issue) begin
            r_last_grant <= w_grant[1];
        end
    end

    // Shift-style 2-entry FIFO: head feeds the outputs, tail refills the head on pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case ({w_issue, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= w_new;
                    end else begin
                        r_tail <= w_new;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= w_new;
                    end else begin
                        r_head <= w_new;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_id     = r_head.id;
    assign rsp_result = r_head.result;
    assign rsp_zero   = r_head.zero;

endmodule
